// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: parametrised multi-digit packed-BCD modulo counter.
// Counts 0..MODULUS-1 over DIGITS decimal digits, with synchronous clear,
// validated parallel load and a combinational carry/borrow for cascading.
// Optional feature macro: BCD_CNT_UPDOWN_EN adds the 'up' direction port
// and down counting; without it the counter is up-only.
module bcd_mod_counter #(
   parameter int DIGITS  = 2,
   parameter int MODULUS = 60
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  clear,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_value,
`ifdef BCD_CNT_UPDOWN_EN
   input  logic                  up,
`endif
   output logic [4*DIGITS-1:0]   count,
   output logic                  carry,
   output logic                  load_err
);

   // Converts a binary integer into packed BCD, least-significant digit at [3:0].
   function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
      int t;
      t = v;
      to_bcd = '0;
      for (int i = 0; i < DIGITS; i++) begin
         to_bcd[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
   endfunction

   localparam logic [4*DIGITS-1:0] MAX_BCD = to_bcd(MODULUS - 1);

   logic                 dir_up;
   logic                 at_max;
   logic                 at_zero;
   logic [4*DIGITS-1:0]  inc_value;
   logic [4*DIGITS-1:0]  dec_value;
   logic [4*DIGITS-1:0]  next_count;
   logic                 load_ok;
   int                   load_dec;
   logic                 digits_ok;

`ifdef BCD_CNT_UPDOWN_EN
   assign dir_up = up;
`else
   assign dir_up = 1'b1;
`endif

   assign at_max  = (count == MAX_BCD);
   assign at_zero = (count == '0);

   // Carry is the terminal-count flag in the current direction, gated by enable only.
   assign carry = enable & (dir_up ? at_max : at_zero);

   // Ripple BCD increment: each digit rolls 9->0 and passes a carry upward.
   always_comb begin
      logic c;
      logic [3:0] d;
      inc_value = count;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         d = count[4*i +: 4];
         if (c) begin
            if (d == 4'd9) begin
               inc_value[4*i +: 4] = 4'd0;
            end else begin
               inc_value[4*i +: 4] = d + 4'd1;
               c = 1'b0;
            end
         end
      end
   end

   // Ripple BCD decrement: each digit rolls 0->9 and borrows from the next digit.
   always_comb begin
      logic b;
      logic [3:0] d;
      dec_value = count;
      b = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         d = count[4*i +: 4];
         if (b) begin
            if (d == 4'd0) begin
               dec_value[4*i +: 4] = 4'd9;
            end else begin
               dec_value[4*i +: 4] = d - 4'd1;
               b = 1'b0;
            end
         end
      end
   end

   // Selects the next enabled value, wrapping at MODULUS-1 (up) or 0 (down).
   always_comb begin
      next_count = count;
      if (dir_up) begin
         next_count = at_max ? '0 : inc_value;
      end else begin
         next_count = at_zero ? MAX_BCD : dec_value;
      end
   end

   // A load is accepted only if every digit is decimal and the value is in range.
   always_comb begin
      logic [3:0] d;
      load_dec  = 0;
      digits_ok = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         d = load_value[4*i +: 4];
         if (d > 4'd9) begin
            digits_ok = 1'b0;
         end
         load_dec = load_dec * 10 + int'(d);
      end
      load_ok = digits_ok && (load_dec < MODULUS);
   end

   // Count register and load-error pulse; priority is clear > load > enable > hold.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count    <= '0;
         load_err <= 1'b0;
      end else begin
         load_err <= 1'b0;
         if (clear) begin
            count <= '0;
         end else if (load) begin
            if (load_ok) begin
               count <= load_value;
            end else begin
               load_err <= 1'b1;
            end
         end else if (enable) begin
            count <= next_count;
         end
      end
   end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb_bcd_mod_counter: scoreboard bench for bcd_mod_counter. The driver pushes
// expected responses from a decimal reference model; a monitor pops and compares.
// Honours BCD_CNT_UPDOWN_EN when it is defined for the build.
module tb_bcd_mod_counter;

   localparam int MOD = 60;

   typedef struct {
      logic       carry;
      logic [7:0] count;
      logic       err;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable, clear, load, up;
   logic [7:0] load_value;
   logic [7:0] count;
   logic       carry, load_err;

   logic       sec_en, sec_ld, hr_ld;
   logic [7:0] sec_lv, hr_lv;
   logic [7:0] sec_count, hr_count;
   logic       sec_carry, hr_carry, sec_err, hr_err;

   exp_t       sb_q[$];
   int         checks   = 0;
   int         failures = 0;
   int         m_val    = 0;
   bit         m_err    = 1'b0;

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) dut (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
      .load_value(load_value),
`ifdef BCD_CNT_UPDOWN_EN
      .up(up),
`endif
      .count(count), .carry(carry), .load_err(load_err)
   );

   bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) sec_cnt (
      .clk(clk), .reset(reset), .enable(sec_en), .clear(1'b0), .load(sec_ld),
      .load_value(sec_lv),
`ifdef BCD_CNT_UPDOWN_EN
      .up(1'b1),
`endif
      .count(sec_count), .carry(sec_carry), .load_err(sec_err)
   );

   bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) hr_cnt (
      .clk(clk), .reset(reset), .enable(sec_carry), .clear(1'b0), .load(hr_ld),
      .load_value(hr_lv),
`ifdef BCD_CNT_UPDOWN_EN
      .up(1'b1),
`endif
      .count(hr_count), .carry(hr_carry), .load_err(hr_err)
   );

   function automatic logic [7:0] bcd8(input int v);
      return {4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Drives one cycle of stimulus and pushes the model's prediction.
   task automatic apply_stimulus(input bit en, input bit clr, input bit ld,
                                 input logic [7:0] lv, input bit dir);
      exp_t e;
      bit   eff_up;
      int   hi, lo;
      @(negedge clk);
      enable     = en;
      clear      = clr;
      load       = ld;
      load_value = lv;
      up         = dir;
`ifdef BCD_CNT_UPDOWN_EN
      eff_up = dir;
`else
      eff_up = 1'b1;
`endif
      e.carry = en && (eff_up ? (m_val == MOD - 1) : (m_val == 0));
      m_err = 1'b0;
      if (clr) begin
         m_val = 0;
      end else if (ld) begin
         hi = int'(lv[7:4]);
         lo = int'(lv[3:0]);
         if (hi <= 9 && lo <= 9 && (hi * 10 + lo) < MOD) m_val = hi * 10 + lo;
         else m_err = 1'b1;
      end else if (en) begin
         m_val = eff_up ? (m_val + 1) % MOD : (m_val + MOD - 1) % MOD;
      end
      e.count = bcd8(m_val);
      e.err   = m_err;
      sb_q.push_back(e);
   endtask

   // Waits (bounded) until every queued prediction has been compared.
   task automatic drain();
      for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
      checks++;
      if (sb_q.size() > 0) begin
         failures++;
         $display("[TB] FAIL drain actual=%0d expected=0 pending entries", sb_q.size());
      end
      @(posedge clk);
      #2;
   endtask

   // Monitor: carry is sampled mid-cycle, count/load_err just after the edge.
   initial begin
      exp_t item;
      forever begin
         @(negedge clk);
         #1;
         if (sb_q.size() > 0) begin
            item = sb_q.pop_front();
            check_output("carry", {15'd0, carry}, {15'd0, item.carry});
            @(posedge clk);
            #1;
            check_output("count", {8'd0, count}, {8'd0, item.count});
            check_output("count_digits_legal", {15'd0, (count[3:0] > 4'd9) || (count[7:4] > 4'd9)}, 16'd0);
            check_output("load_err", {15'd0, load_err}, {15'd0, item.err});
         end
      end
   end

   // Global time limit so the run always terminates.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] lv;
      int         v;
      reset = 1'b0; enable = 1'b0; clear = 1'b0; load = 1'b0; up = 1'b1;
      load_value = 8'h00;
      sec_en = 1'b0; sec_ld = 1'b0; hr_ld = 1'b0; sec_lv = 8'h00; hr_lv = 8'h00;

      // Reset state.
      #10;
      check_output("reset_count", {8'd0, count}, 16'h0000);
      check_output("reset_load_err", {15'd0, load_err}, 16'h0000);
      check_output("reset_carry", {15'd0, carry}, 16'h0000);
      #10;
      reset = 1'b1;

      // Disabled hold, then a full 00..59..00 sweep.
      for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < MOD; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

      // Valid load, continue counting, then invalid loads and back-to-back invalids.
      apply_stimulus(1'b1, 1'b0, 1'b1, 8'h45, 1'b1);
      apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      apply_stimulus(1'b1, 1'b0, 1'b1, 8'h6A, 1'b1);
      apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      apply_stimulus(1'b1, 1'b0, 1'b1, 8'h72, 1'b1);
      apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      apply_stimulus(1'b0, 1'b0, 1'b1, 8'hAA, 1'b1);
      apply_stimulus(1'b0, 1'b0, 1'b1, 8'h60, 1'b1);
      apply_stimulus(1'b0, 1'b0, 1'b1, 8'h59, 1'b1);

      // Clear beats a concurrent load and enable.
      apply_stimulus(1'b0, 1'b0, 1'b1, 8'h17, 1'b1);
      apply_stimulus(1'b1, 1'b1, 1'b1, 8'h30, 1'b1);

`ifdef BCD_CNT_UPDOWN_EN
      // Down counting through the wrap, then a direction change.
      apply_stimulus(1'b0, 1'b0, 1'b1, 8'h01, 1'b1);
      apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
`endif

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(1) == 1) begin
            lv = 8'($urandom_range(255));
         end else begin
            v  = int'($urandom_range(MOD - 1));
            lv = bcd8(v);
         end
         apply_stimulus($urandom_range(3) != 0, $urandom_range(15) == 0,
                        $urandom_range(7) == 0, lv, 1'($urandom_range(1)));
      end
      drain();

      // Async reset mid-cycle with count 33 and load_err high.
      apply_stimulus(1'b0, 1'b0, 1'b1, 8'h33, 1'b1);
      apply_stimulus(1'b0, 1'b0, 1'b1, 8'h7A, 1'b1);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check_output("async_reset_count", {8'd0, count}, 16'h0000);
      check_output("async_reset_load_err", {15'd0, load_err}, 16'h0000);
      load = 1'b0;
      enable = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      m_val = 0;
      m_err = 1'b0;
      for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      drain();

      // Cascade: 23:58 -> 23:59 -> 00:00 with both stages wrapping together.
      @(negedge clk);
      sec_ld = 1'b1; sec_lv = 8'h58;
      hr_ld  = 1'b1; hr_lv  = 8'h23;
      @(negedge clk);
      sec_ld = 1'b0; hr_ld = 1'b0; sec_en = 1'b1;
      #1;
      check_output("cascade_load_sec", {8'd0, sec_count}, 16'h0058);
      check_output("cascade_load_hr", {8'd0, hr_count}, 16'h0023);
      check_output("cascade_carry_early", {15'd0, sec_carry}, 16'h0000);
      @(negedge clk);
      #1;
      check_output("cascade_sec_59", {8'd0, sec_count}, 16'h0059);
      check_output("cascade_hr_23", {8'd0, hr_count}, 16'h0023);
      check_output("cascade_sec_carry", {15'd0, sec_carry}, 16'h0001);
      check_output("cascade_hr_carry", {15'd0, hr_carry}, 16'h0001);
      @(posedge clk);
      #1;
      sec_en = 1'b0;
      check_output("cascade_wrap_sec", {8'd0, sec_count}, 16'h0000);
      check_output("cascade_wrap_hr", {8'd0, hr_count}, 16'h0000);
      check_output("cascade_errs", {14'd0, sec_err, hr_err}, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
